// File: rtl/midi_out.sv
// MIDI transmitter: turns one status/data request into 1-3 UART bytes
// (8N1, LSB first), dropping the status byte when it repeats the last
// channel status sent (running status).
module midi_out #(
  parameter int CLKS_PER_BIT   = 1600,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] inStatus,
  input  logic [6:0] inData1,
  input  logic [6:0] inData2,
  input  logic       inValid,
  output logic       outReady,
  output logic       uartStream,
  output logic       outBusy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]      state;
  logic [1:0]      byteIdx;
  logic [1:0]      lastIdx;
  logic [2:0]      bitIdx;
  logic [CW-1:0]   baudCnt;
  logic [3:0][7:0] msgBytes;
  logic [7:0]      lastStatus;
  logic            lastValid;
  logic            started;
  logic            line;

  logic            accept;
  logic            isChan;
  logic            isRealtime;
  logic            isTwo;
  logic            skipStatus;
  logic            bitEnd;
  logic [7:0]      curByte;
  logic            go;
  logic [1:0]      nextLast;
  logic [3:0][7:0] nextBytes;

  assign accept     = inValid && outReady;
  assign isChan     = inStatus[7] && (inStatus[7:4] != 4'hF);
  assign isRealtime = (inStatus[7:3] == 5'b11111);
  assign isTwo      = (inStatus[7:5] == 3'b110);
  assign skipStatus = RUNNING_STATUS && isChan && lastValid && (inStatus == lastStatus);
  assign bitEnd     = (baudCnt == BIT_LAST);
  assign curByte    = msgBytes[byteIdx];

  // Build the byte list for the request; go=0 means discard it silently
  always_comb begin
    go        = 1'b0;
    nextLast  = 2'd0;
    nextBytes = '0;
    if (isRealtime) begin
      go           = 1'b1;
      nextBytes[0] = inStatus;
    end else if (isChan) begin
      go = 1'b1;
      if (skipStatus) begin
        nextBytes[0] = {1'b0, inData1};
        nextBytes[1] = {1'b0, inData2};
        nextLast     = isTwo ? 2'd0 : 2'd1;
      end else begin
        nextBytes[0] = inStatus;
        nextBytes[1] = {1'b0, inData1};
        nextBytes[2] = {1'b0, inData2};
        nextLast     = isTwo ? 2'd1 : 2'd2;
      end
    end
  end

  // Byte/bit sequencer; the line register is loaded one cycle ahead of each bit
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      byteIdx    <= 2'd0;
      lastIdx    <= 2'd0;
      bitIdx     <= 3'd0;
      baudCnt    <= '0;
      msgBytes   <= '0;
      lastStatus <= 8'h00;
      lastValid  <= 1'b0;
      started    <= 1'b0;
      line       <= 1'b1;
    end else begin
      started <= 1'b1;
      case (state)
        IDLE: begin
          if (accept && go) begin
            msgBytes <= nextBytes;
            lastIdx  <= nextLast;
            byteIdx  <= 2'd0;
            bitIdx   <= 3'd0;
            baudCnt  <= '0;
            line     <= 1'b0;
            state    <= START;
            if (isChan) begin
              lastStatus <= inStatus;
              lastValid  <= 1'b1;
            end
          end
        end
        START: begin
          if (bitEnd) begin
            baudCnt <= '0;
            bitIdx  <= 3'd0;
            line    <= curByte[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + CW'(1);
          end
        end
        DATA: begin
          if (bitEnd) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
              line  <= 1'b1;
              state <= STOP;
            end else begin
              bitIdx <= bitIdx + 3'd1;
              line   <= curByte[bitIdx + 3'd1];
            end
          end else begin
            baudCnt <= baudCnt + CW'(1);
          end
        end
        STOP: begin
          if (bitEnd) begin
            baudCnt <= '0;
            if (byteIdx == lastIdx) begin
              state <= IDLE;
            end else begin
              byteIdx <= byteIdx + 2'd1;
              line    <= 1'b0;
              state   <= START;
            end
          end else begin
            baudCnt <= baudCnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign outReady   = started && (state == IDLE);
  assign outBusy    = (state != IDLE);
  assign uartStream = line;

endmodule
